// File: rtl/ram_bit_collector_if.sv
// Serial-bit input and RAM write port bundle for ram_bit_collector.
// The collector attaches through the slave modport.
// The producer / RAM side attaches through the master modport.
interface ram_bit_collector_if #(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 4,
    parameter int ADDR_WIDTH = 8
);
    logic                  in_bit;
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic                  ram_we;
    logic                  ram_ready;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_wmask;
    logic [SEL_WIDTH-1:0]  bit_pos;
    logic                  wrapped;

    modport master (
        output in_bit, in_valid, flush, ram_ready,
        input  in_ready, ram_we, ram_addr, ram_wdata, ram_wmask, bit_pos, wrapped
    );

    modport slave (
        input  in_bit, in_valid, flush, ram_ready,
        output in_ready, ram_we, ram_addr, ram_wdata, ram_wmask, bit_pos, wrapped
    );
endinterface

// File: rtl/ram_bit_collector.sv
// Serial bit collector feeding a RAM write port.
// Bits are packed LSB first at index bit_pos, which is the same indexing the
// per-bit read multiplexer uses. A completed word, or a flushed partial word,
// is written at an auto-incrementing address together with a fill mask.
module ram_bit_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_bit_collector_if.slave    bus
);

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam logic [SEL_WIDTH-1:0]  LAST_POS = SEL_WIDTH'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    state_t                state_q;
    state_t                state_d;
    logic [SEL_WIDTH-1:0]  bit_pos_q;
    logic [SEL_WIDTH-1:0]  bit_pos_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [DATA_WIDTH-1:0] wmask_q;
    logic [DATA_WIDTH-1:0] wmask_d;
    logic                  wrapped_q;
    logic                  wrapped_d;
    logic                  ready_int;
    logic                  accept;

    // Ready only depends on state and reset, never on the incoming bit.
    assign ready_int = rst_n && (state_q == FILL);
    assign accept    = bus.in_valid && ready_int;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-datapath computation.
    always_comb begin
        state_d   = state_q;
        bit_pos_d = bit_pos_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        wrapped_d = 1'b0;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    // A flush arriving with a bit includes that bit first; if
                    // the bit completes the word the flush is simply absorbed.
                    wdata_d[bit_pos_q] = bus.in_bit;
                    wmask_d[bit_pos_q] = 1'b1;
                    bit_pos_d          = bit_pos_q + SEL_WIDTH'(1);
                    if ((bit_pos_q == LAST_POS) || bus.flush) begin
                        state_d = WRITE;
                    end
                end else if (bus.flush && (bit_pos_q != '0)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (bus.ram_ready) begin
                    state_d   = FILL;
                    bit_pos_d = '0;
                    wdata_d   = '0;
                    wmask_d   = '0;
                    addr_d    = addr_q + ADDR_WIDTH'(1);
                    wrapped_d = (addr_q == ADDR_MAX);
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Datapath registers; a partial word is dropped on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_pos_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            bit_pos_q <= bit_pos_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign bus.in_ready  = ready_int;
    assign bus.ram_we    = (state_q == WRITE);
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_wmask = wmask_q;
    assign bus.bit_pos   = bit_pos_q;
    assign bus.wrapped   = wrapped_q;

endmodule

// File: tb/tb_ram_bit_collector.sv
// Self-checking bench for ram_bit_collector: directed scenarios plus a
// randomized run compared against a queue-based word model.
module tb_ram_bit_collector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    ram_bit_collector_if #(.DATA_WIDTH(16), .SEL_WIDTH(4), .ADDR_WIDTH(8)) bus ();
    ram_bit_collector_if #(.DATA_WIDTH(16), .SEL_WIDTH(4), .ADDR_WIDTH(2)) bus2 ();

    ram_bit_collector #(.DATA_WIDTH(16), .SEL_WIDTH(4), .ADDR_WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ram_bit_collector #(.DATA_WIDTH(16), .SEL_WIDTH(4), .ADDR_WIDTH(2)) u_dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // Reference model: the word under construction is a queue of bits.
    bit         mq[$];
    bit         m_pend;
    logic [7:0] m_addr;
    logic       m_wrap;

    function automatic logic [15:0] m_data();
        logic [15:0] d = '0;
        foreach (mq[i]) d[i] = mq[i];
        return d;
    endfunction

    function automatic logic [15:0] m_mask();
        logic [15:0] m = '0;
        foreach (mq[i]) m[i] = 1'b1;
        return m;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_pend = 1'b0;
        m_addr = '0;
        m_wrap = 1'b0;
    endfunction

    function automatic void model_step(input logic v, input logic b, input logic f, input logic r);
        m_wrap = 1'b0;
        if (m_pend) begin
            if (r) begin
                m_wrap = (m_addr == 8'hFF);
                m_addr = m_addr + 8'd1;
                mq.delete();
                m_pend = 1'b0;
            end
        end else begin
            if (v) mq.push_back(b);
            if (mq.size() == 16 || (f && mq.size() > 0)) m_pend = 1'b1;
        end
    endfunction

    task automatic idle_inputs();
        bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.flush = 1'b0; bus.ram_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_bit = 1'b0; bus2.flush = 1'b0; bus2.ram_ready = 1'b0;
    endtask

    task automatic tick(input logic v, input logic b, input logic f, input logic r);
        bus.in_valid = v; bus.in_bit = b; bus.flush = f; bus.ram_ready = r;
        @(posedge clk);
        model_step(v, b, f, r);
        #1;
    endtask

    task automatic tick2(input logic v, input logic b, input logic f, input logic r);
        bus2.in_valid = v; bus2.in_bit = b; bus2.flush = f; bus2.ram_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w, input logic r);
        for (int i = 0; i < 16; i++) tick(1'b1, w[i], 1'b0, r);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got=%0b exp=0", bus.in_ready); end
        vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL rst_ram_we got=%0b exp=0", bus.ram_we); end
        vectors++; if (bus.ram_addr !== 8'h00) begin miscompares++; $display("FAIL rst_ram_addr got=%h exp=00", bus.ram_addr); end
        vectors++; if (bus.ram_wdata !== 16'h0000) begin miscompares++; $display("FAIL rst_wdata got=%h exp=0000", bus.ram_wdata); end
        vectors++; if (bus.ram_wmask !== 16'h0000) begin miscompares++; $display("FAIL rst_wmask got=%h exp=0000", bus.ram_wmask); end
        vectors++; if (bus.bit_pos !== 4'd0) begin miscompares++; $display("FAIL rst_bit_pos got=%0d exp=0", bus.bit_pos); end
        vectors++; if (bus.wrapped !== 1'b0) begin miscompares++; $display("FAIL rst_wrapped got=%0b exp=0", bus.wrapped); end
        #2 rst_n = 1'b1;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_in_ready got=%0b exp=1", bus.in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_word();
        logic [15:0] w = 16'h8E8E;
        logic [15:0] w2;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            vectors++; if (bus.bit_pos !== 4'(i)) begin miscompares++; $display("FAIL full_bit_pos got=%0d exp=%0d", bus.bit_pos, i); end
            tick(1'b1, w[i], 1'b0, 1'b1);
        end
        vectors++; if (bus.ram_we !== 1'b1) begin miscompares++; $display("FAIL full_we got=%0b exp=1", bus.ram_we); end
        vectors++; if (bus.ram_addr !== 8'h00) begin miscompares++; $display("FAIL full_addr got=%h exp=00", bus.ram_addr); end
        vectors++; if (bus.ram_wdata !== 16'h8E8E) begin miscompares++; $display("FAIL full_wdata got=%h exp=8e8e", bus.ram_wdata); end
        vectors++; if (bus.ram_wmask !== 16'hFFFF) begin miscompares++; $display("FAIL full_wmask got=%h exp=ffff", bus.ram_wmask); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready got=%0b exp=0", bus.in_ready); end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL full_we_drop got=%0b exp=0", bus.ram_we); end
        vectors++; if (bus.ram_wdata !== 16'h0000) begin miscompares++; $display("FAIL full_wdata_clear got=%h exp=0000", bus.ram_wdata); end
        w2 = 16'($urandom);
        send_word(w2, 1'b1);
        vectors++; if (bus.ram_addr !== 8'h01) begin miscompares++; $display("FAIL full_second_addr got=%h exp=01", bus.ram_addr); end
        vectors++; if (bus.ram_wdata !== w2) begin miscompares++; $display("FAIL full_second_wdata got=%h exp=%h", bus.ram_wdata, w2); end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_partial_flush();
        logic [4:0] p = 5'b01101;
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, p[i], 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        vectors++; if (bus.ram_we !== 1'b1) begin miscompares++; $display("FAIL flush_we got=%0b exp=1", bus.ram_we); end
        vectors++; if (bus.ram_wdata !== 16'h000D) begin miscompares++; $display("FAIL flush_wdata got=%h exp=000d", bus.ram_wdata); end
        vectors++; if (bus.ram_wmask !== 16'h001F) begin miscompares++; $display("FAIL flush_wmask got=%h exp=001f", bus.ram_wmask); end
        vectors++; if (bus.ram_addr !== 8'h00) begin miscompares++; $display("FAIL flush_addr got=%h exp=00", bus.ram_addr); end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        vectors++; if (bus.bit_pos !== 4'd0) begin miscompares++; $display("FAIL flush_bit_pos_after got=%0d exp=0", bus.bit_pos); end
        vectors++; if (bus.ram_addr !== 8'h01) begin miscompares++; $display("FAIL flush_addr_after got=%h exp=01", bus.ram_addr); end
        vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL flush_we_after got=%0b exp=0", bus.ram_we); end
    endtask

    task automatic test_backpressure();
        logic [15:0] w;
        do_reset();
        w = 16'($urandom);
        send_word(w, 1'b0);
        for (int c = 0; c < 4; c++) begin
            vectors++; if (bus.ram_we !== 1'b1) begin miscompares++; $display("FAIL bp_we c=%0d got=%0b exp=1", c, bus.ram_we); end
            vectors++; if (bus.ram_addr !== 8'h00) begin miscompares++; $display("FAIL bp_addr c=%0d got=%h exp=00", c, bus.ram_addr); end
            vectors++; if (bus.ram_wdata !== w) begin miscompares++; $display("FAIL bp_wdata c=%0d got=%h exp=%h", c, bus.ram_wdata, w); end
            vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready c=%0d got=%0b exp=0", c, bus.in_ready); end
            tick(1'b1, 1'($urandom), 1'($urandom), (c == 3) ? 1'b1 : 1'b0);
        end
        vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL bp_we_after got=%0b exp=0", bus.ram_we); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_in_ready_after got=%0b exp=1", bus.in_ready); end
        vectors++; if (bus.ram_addr !== 8'h01) begin miscompares++; $display("FAIL bp_addr_after got=%h exp=01", bus.ram_addr); end
        vectors++; if (bus.bit_pos !== 4'd0) begin miscompares++; $display("FAIL bp_bit_pos_after got=%0d exp=0", bus.bit_pos); end
    endtask

    task automatic test_flush_cases();
        logic [15:0] w;
        do_reset();
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL idle_flush_we got=%0b exp=0", bus.ram_we); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL idle_flush_in_ready got=%0b exp=1", bus.in_ready); end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL idle_flush_we2 got=%0b exp=0", bus.ram_we); end
        w = 16'($urandom);
        for (int i = 0; i < 15; i++) tick(1'b1, w[i], 1'b0, 1'b1);
        tick(1'b1, w[15], 1'b1, 1'b1);
        vectors++; if (bus.ram_we !== 1'b1) begin miscompares++; $display("FAIL sim_flush_we got=%0b exp=1", bus.ram_we); end
        vectors++; if (bus.ram_wmask !== 16'hFFFF) begin miscompares++; $display("FAIL sim_flush_wmask got=%h exp=ffff", bus.ram_wmask); end
        vectors++; if (bus.ram_wdata !== w) begin miscompares++; $display("FAIL sim_flush_wdata got=%h exp=%h", bus.ram_wdata, w); end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL sim_flush_we_drop got=%0b exp=0", bus.ram_we); end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL sim_flush_no_second got=%0b exp=0", bus.ram_we); end
        vectors++; if (bus.ram_addr !== 8'h01) begin miscompares++; $display("FAIL sim_flush_addr got=%h exp=01", bus.ram_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 16; i++) tick2(1'b1, (i == 0) ? 1'b1 : 1'b0, 1'b0, 1'b1);
            vectors++; if (bus2.ram_we !== 1'b1) begin miscompares++; $display("FAIL wrap_we k=%0d got=%0b exp=1", k, bus2.ram_we); end
            vectors++; if (bus2.ram_addr !== 2'(k % 4)) begin miscompares++; $display("FAIL wrap_addr k=%0d got=%0d exp=%0d", k, bus2.ram_addr, k % 4); end
            vectors++; if (bus2.ram_wdata !== 16'h0001) begin miscompares++; $display("FAIL wrap_wdata k=%0d got=%h exp=0001", k, bus2.ram_wdata); end
            vectors++; if (bus2.wrapped !== 1'b0) begin miscompares++; $display("FAIL wrap_pre k=%0d got=%0b exp=0", k, bus2.wrapped); end
            tick2(1'b0, 1'b0, 1'b0, 1'b1);
            vectors++; if (bus2.wrapped !== ((k == 3) ? 1'b1 : 1'b0)) begin miscompares++; $display("FAIL wrap_pulse k=%0d got=%0b exp=%0b", k, bus2.wrapped, (k == 3)); end
            tick2(1'b0, 1'b0, 1'b0, 1'b1);
            vectors++; if (bus2.wrapped !== 1'b0) begin miscompares++; $display("FAIL wrap_pulse_end k=%0d got=%0b exp=0", k, bus2.wrapped); end
        end
        vectors++; if (bus2.ram_addr !== 2'd1) begin miscompares++; $display("FAIL wrap_final_addr got=%0d exp=1", bus2.ram_addr); end
        idle_inputs();
    endtask

    task automatic test_reset_midfill();
        logic [15:0] w;
        do_reset();
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_in_ready got=%0b exp=0", bus.in_ready); end
        vectors++; if (bus.bit_pos !== 4'd0) begin miscompares++; $display("FAIL mid_rst_bit_pos got=%0d exp=0", bus.bit_pos); end
        vectors++; if (bus.ram_wdata !== 16'h0000) begin miscompares++; $display("FAIL mid_rst_wdata got=%h exp=0000", bus.ram_wdata); end
        vectors++; if (bus.ram_wmask !== 16'h0000) begin miscompares++; $display("FAIL mid_rst_wmask got=%h exp=0000", bus.ram_wmask); end
        vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL mid_rst_we got=%0b exp=0", bus.ram_we); end
        idle_inputs();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        w = 16'($urandom) & 16'hFF00;
        send_word(w, 1'b1);
        vectors++; if (bus.ram_we !== 1'b1) begin miscompares++; $display("FAIL mid_word_we got=%0b exp=1", bus.ram_we); end
        vectors++; if (bus.ram_addr !== 8'h00) begin miscompares++; $display("FAIL mid_word_addr got=%h exp=00", bus.ram_addr); end
        vectors++; if (bus.ram_wdata !== w) begin miscompares++; $display("FAIL mid_word_wdata got=%h exp=%h", bus.ram_wdata, w); end
        vectors++; if (bus.ram_wmask !== 16'hFFFF) begin miscompares++; $display("FAIL mid_word_wmask got=%h exp=ffff", bus.ram_wmask); end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic v, b, f, r;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            v = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
            b = 1'($urandom);
            f = ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0;
            r = ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0;
            tick(v, b, f, r);
            vectors++; if (bus.in_ready !== !m_pend) begin miscompares++; $display("FAIL rnd_in_ready n=%0d got=%0b exp=%0b", n, bus.in_ready, !m_pend); end
            vectors++; if (bus.ram_we !== m_pend) begin miscompares++; $display("FAIL rnd_we n=%0d got=%0b exp=%0b", n, bus.ram_we, m_pend); end
            vectors++; if (bus.ram_addr !== m_addr) begin miscompares++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, bus.ram_addr, m_addr); end
            vectors++; if (bus.ram_wdata !== m_data()) begin miscompares++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, bus.ram_wdata, m_data()); end
            vectors++; if (bus.ram_wmask !== m_mask()) begin miscompares++; $display("FAIL rnd_wmask n=%0d got=%h exp=%h", n, bus.ram_wmask, m_mask()); end
            vectors++; if (bus.bit_pos !== 4'(mq.size())) begin miscompares++; $display("FAIL rnd_bit_pos n=%0d got=%0d exp=%0d", n, bus.bit_pos, 4'(mq.size())); end
            vectors++; if (bus.wrapped !== m_wrap) begin miscompares++; $display("FAIL rnd_wrapped n=%0d got=%0b exp=%0b", n, bus.wrapped, m_wrap); end
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_full_word();
        test_partial_flush();
        test_backpressure();
        test_flush_cases();
        test_wrap();
        test_reset_midfill();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_bit_collector.md
Name: ram_bit_collector

Overview:
- Write-side counterpart of the per-bit RAM read multiplexer in the number converter datapath.
- Accepts a serial stream of single bits with a valid/ready handshake and places bit k of each word at index k, LSB first. This is the same bit indexing the read multiplexer uses when its select counts 0..15.
- Writes each completed word to a RAM port at an auto-incrementing address.
- A flush input writes a partially filled word together with a bit mask.

Parameters:
- DATA_WIDTH, 16, RAM word width in bits.
- SEL_WIDTH, 4, width of the bit-position counter; must equal log2(DATA_WIDTH).
- ADDR_WIDTH, 8, RAM address width; addresses wrap modulo 2^ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  collector can accept a bit this cycle.
- flush  input  1  request to write the current partial word.
- ram_we  output  1  write request to RAM; held until accepted.
- ram_ready  input  1  RAM accepts the write this cycle.
- ram_addr  output  ADDR_WIDTH  write address.
- ram_wdata  output  DATA_WIDTH  assembled word; bits not filled are 0.
- ram_wmask  output  DATA_WIDTH  1 = bit position filled in this word.
- bit_pos  output  SEL_WIDTH  index the next accepted bit will occupy.
- wrapped  output  1  one-cycle pulse when ram_addr wraps from max to 0.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=FILL, bit_pos=0, ram_addr=0.
  - ram_we=0, ram_wdata=0, ram_wmask=0, wrapped=0.
  - in_ready=0 while rst_n is low; in_ready=1 from the first cycle after release.
  - A partial word in progress is discarded; no write is issued.
- State FILL:
  - in_ready=1, ram_we=0.
  - Accept condition: in_valid&&in_ready. On accept: ram_wdata[bit_pos]<=in_bit, ram_wmask[bit_pos]<=1, bit_pos<=bit_pos+1.
  - Accepting at bit_pos==DATA_WIDTH-1 moves to WRITE next cycle, with bit_pos=0 and ram_wmask all ones.
  - flush with no accept and bit_pos>0: move to WRITE with the current partial ram_wdata and ram_wmask.
  - flush with bit_pos==0 and no accept: ignored; no write.
  - flush together with an accepted bit: the bit is accepted first and included in the mask.
    - If that bit completes the word, exactly one full write occurs and the flush is consumed.
    - Otherwise, move to WRITE with the partial mask.
- State WRITE:
  - in_ready=0, ram_we=1.
  - ram_addr, ram_wdata and ram_wmask are held stable until ram_ready.
  - flush is ignored in this state.
  - On ram_we&&ram_ready:
    - next cycle state=FILL, ram_we=0, ram_wdata=0, ram_wmask=0, bit_pos=0.
    - ram_addr<=ram_addr+1.
    - If ram_addr was 2^ADDR_WIDTH-1: ram_addr becomes 0 and wrapped=1 for exactly that following cycle.
- Timing:
  - Latency from the 16th accepted bit to ram_we=1 is 1 cycle.
  - With ram_ready tied high, the minimum period is DATA_WIDTH+1 cycles per word (one bubble cycle in WRITE).
- Widths:
  - bit_pos arithmetic is modulo 2^SEL_WIDTH.
  - ram_addr arithmetic is modulo 2^ADDR_WIDTH; no overflow flag beyond the wrapped pulse.
- in_bit is ignored whenever in_valid=0 or in_ready=0.
- Outputs are registered; there is no combinational path from in_valid or in_bit to ram_* outputs.

Test Plan:
- Bit order and full word: after reset, send bits of 16'h8E8E LSB first (0,1,1,1,0,0,0,1,...) on consecutive cycles, ram_ready=1 -> one cycle later ram_we=1, ram_addr=0, ram_wdata=16'h8E8E, ram_wmask=16'hFFFF. The next word is written to ram_addr=1.
- Partial flush: send 1,0,1,1,0 then pulse flush -> ram_wdata=16'h000D, ram_wmask=16'h001F, ram_addr=0. Afterwards bit_pos=0 and ram_addr=1.
- Backpressure: complete a word with ram_ready=0 for 3 cycles -> ram_we, ram_addr and ram_wdata stay stable and in_ready=0 for those cycles. On the 4th cycle ram_ready=1 -> write accepted and in_ready=1 the next cycle.
- Ignored flush and simultaneous flush: flush at bit_pos=0 -> no ram_we. flush together with the 16th bit -> exactly one write with mask 16'hFFFF.
- Wrap: ADDR_WIDTH=2, write 5 words of 16'h0001 -> addresses 0,1,2,3,0, with wrapped=1 for one cycle after the address-3 write is accepted.
- Reset mid-fill: accept 7 bits, then assert rst_n=0 asynchronously mid-cycle -> all outputs are 0 immediately. After release, a fresh 16-bit word is written at ram_addr=0 with no residue from the first 7 bits.
